// File: rtl/reorder_buffer_if.sv
// Reorder buffer bus: issue, CDB broadcast, two operand query ports,
// commit and flush. The master side is the core front end (dispatch / CDB
// arbiter / RS); the slave side is the reorder buffer itself.
interface reorder_buffer_if #(
    parameter int ROB_ADDR = 3
);
    // issue
    logic                issue_valid;
    logic [1:0]          issue_type;
    logic [4:0]          issue_rd;
    logic [31:0]         issue_pc;
    logic                issue_pred;
    logic                issue_ready;
    logic [31:0]         issue_value;
    logic [ROB_ADDR-1:0] issue_tag;
    logic                rob_full;

    // common data bus
    logic                cdb_valid;
    logic [ROB_ADDR-1:0] cdb_tag;
    logic [31:0]         cdb_value;
    logic                cdb_taken;
    logic [31:0]         cdb_target;

    // operand queries
    logic [ROB_ADDR-1:0] qa_tag;
    logic [ROB_ADDR-1:0] qb_tag;
    logic                qa_ready;
    logic                qb_ready;
    logic [31:0]         qa_value;
    logic [31:0]         qb_value;

    // retirement and redirect
    logic                commit_valid;
    logic [ROB_ADDR-1:0] commit_tag;
    logic [4:0]          commit_rd;
    logic [31:0]         commit_value;
    logic                commit_store;
    logic                flush;
    logic [31:0]         flush_pc;

    modport master (
        output issue_valid, issue_type, issue_rd, issue_pc, issue_pred, issue_ready, issue_value,
        input  issue_tag, rob_full,
        output cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        output qa_tag, qb_tag,
        input  qa_ready, qb_ready, qa_value, qb_value,
        input  commit_valid, commit_tag, commit_rd, commit_value, commit_store, flush, flush_pc
    );

    modport slave (
        input  issue_valid, issue_type, issue_rd, issue_pc, issue_pred, issue_ready, issue_value,
        output issue_tag, rob_full,
        input  cdb_valid, cdb_tag, cdb_value, cdb_taken, cdb_target,
        input  qa_tag, qb_tag,
        output qa_ready, qb_ready, qa_value, qb_value,
        output commit_valid, commit_tag, commit_rd, commit_value, commit_store, flush, flush_pc
    );
endinterface

// File: rtl/reorder_buffer.sv
// Circular reorder buffer for the Tomasulo core. Allocates a tag per issued
// instruction at the tail, captures CDB results, retires one entry per cycle
// from the head in program order and raises a flush on branch mispredict.
module reorder_buffer #(
    parameter int ROB_ADDR = 3
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic           rdy_in,
    reorder_buffer_if.slave rob
);
    localparam int DEPTH = 1 << ROB_ADDR;

    typedef logic [ROB_ADDR-1:0] tag_t;
    typedef logic [ROB_ADDR:0]   cnt_t;

    typedef enum logic [1:0] {
        T_REG    = 2'd0,
        T_STORE  = 2'd1,
        T_BRANCH = 2'd2,
        T_OTHER  = 2'd3
    } op_type_e;

    typedef struct packed {
        op_type_e    op;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        pred;
        logic [31:0] value;
        logic        taken;
        logic [31:0] target;
    } payload_t;

    // Control state: reset to empty
    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] ready_q;
    tag_t             head_q;
    tag_t             tail_q;
    cnt_t             count_q;

    // Entry payload: only meaningful while the entry is busy
    payload_t         payload_q [DEPTH];

    // Registered outputs
    logic             commit_valid_q;
    tag_t             commit_tag_q;
    logic [4:0]       commit_rd_q;
    logic [31:0]      commit_value_q;
    logic             commit_store_q;
    logic             flush_q;
    logic [31:0]      flush_pc_q;

    logic             full;
    logic             commit_now;
    logic             mispredict;
    logic             issue_now;
    logic             cdb_hit;
    payload_t         head_entry;

    assign full = (count_q == cnt_t'(DEPTH));

    // Per-cycle decisions: what retires, whether it redirects, what is accepted
    always_comb begin
        // NOTE: combinational blocks use blocking '=', clocked blocks use '<=' only.
        head_entry = payload_q[head_q];
        commit_now = rdy_in & busy_q[head_q] & ready_q[head_q];
        mispredict = commit_now & (head_entry.op == T_BRANCH) & (head_entry.taken != head_entry.pred);
        // A mispredict in flight (this edge or just signalled) makes the issuing instruction wrong-path.
        issue_now  = rdy_in & rob.issue_valid & ~full & ~mispredict & ~flush_q;
        cdb_hit    = rdy_in & rob.cdb_valid & busy_q[rob.cdb_tag];
    end

    // Pointer, occupancy and per-entry busy/ready bookkeeping
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (mispredict) begin
            busy_q  <= '0;
            ready_q <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (cdb_hit) begin
                ready_q[rob.cdb_tag] <= 1'b1;
            end
            if (commit_now) begin
                busy_q[head_q]  <= 1'b0;
                ready_q[head_q] <= 1'b0;
                head_q          <= head_q + tag_t'(1);
            end
            if (issue_now) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= rob.issue_ready;
                tail_q          <= tail_q + tag_t'(1);
            end
            count_q <= count_q + cnt_t'(issue_now) - cnt_t'(commit_now);
        end
    end

    // Payload capture at issue and on CDB broadcast
    // NOTE: the payload array has no reset; busy/ready gate every use of it.
    always_ff @(posedge clk_in) begin
        if (cdb_hit) begin
            payload_q[rob.cdb_tag].value  <= rob.cdb_value;
            payload_q[rob.cdb_tag].taken  <= rob.cdb_taken;
            payload_q[rob.cdb_tag].target <= rob.cdb_target;
        end
        if (issue_now) begin
            payload_q[tail_q] <= '{
                op:     op_type_e'(rob.issue_type),
                rd:     rob.issue_rd,
                pc:     rob.issue_pc,
                pred:   rob.issue_pred,
                value:  rob.issue_value,
                taken:  1'b0,
                target: 32'd0
            };
        end
    end

    // Registered retirement pulses and redirect PC
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            commit_valid_q <= 1'b0;
            commit_tag_q   <= '0;
            commit_rd_q    <= '0;
            commit_value_q <= '0;
            commit_store_q <= 1'b0;
            flush_q        <= 1'b0;
            flush_pc_q     <= '0;
        end else begin
            commit_valid_q <= commit_now;
            commit_store_q <= commit_now & (head_entry.op == T_STORE);
            flush_q        <= mispredict;
            if (commit_now) begin
                commit_tag_q   <= head_q;
                commit_rd_q    <= (head_entry.op == T_REG) ? head_entry.rd : 5'd0;
                commit_value_q <= head_entry.value;
            end
            if (mispredict) begin
                flush_pc_q <= head_entry.taken ? head_entry.target : head_entry.pc + 32'd4;
            end
        end
    end

    // Operand lookup with same-cycle CDB bypass; non-busy tags read as not ready, zero
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        rob.qa_ready = 1'b0;
        rob.qa_value = 32'd0;
        rob.qb_ready = 1'b0;
        rob.qb_value = 32'd0;
        if (busy_q[rob.qa_tag]) begin
            if (rob.cdb_valid && rob.cdb_tag == rob.qa_tag) begin
                rob.qa_ready = 1'b1;
                rob.qa_value = rob.cdb_value;
            end else if (ready_q[rob.qa_tag]) begin
                rob.qa_ready = 1'b1;
                rob.qa_value = payload_q[rob.qa_tag].value;
            end
        end
        if (busy_q[rob.qb_tag]) begin
            if (rob.cdb_valid && rob.cdb_tag == rob.qb_tag) begin
                rob.qb_ready = 1'b1;
                rob.qb_value = rob.cdb_value;
            end else if (ready_q[rob.qb_tag]) begin
                rob.qb_ready = 1'b1;
                rob.qb_value = payload_q[rob.qb_tag].value;
            end
        end
    end

    assign rob.issue_tag    = tail_q;
    assign rob.rob_full     = full;
    assign rob.commit_valid = commit_valid_q;
    assign rob.commit_tag   = commit_tag_q;
    assign rob.commit_rd    = commit_rd_q;
    assign rob.commit_value = commit_value_q;
    assign rob.commit_store = commit_store_q;
    assign rob.flush        = flush_q;
    assign rob.flush_pc     = flush_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: a table of directed vectors,
// hand-written multi-cycle sequences and a randomized run against a
// queue-based model of in-order retirement.
module tb_reorder_buffer;
    localparam int RA    = 3;
    localparam int DEPTH = 8;

    logic clk_in;
    logic rst_in;
    logic rdy_in;

    reorder_buffer_if #(.ROB_ADDR(RA)) rob ();

    reorder_buffer #(.ROB_ADDR(RA)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .rob    (rob)
    );

    int n_checks = 0;
    int n_fail   = 0;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        rdy_in          = 1'b1;
        rob.issue_valid = 1'b0;
        rob.issue_type  = 2'd0;
        rob.issue_rd    = 5'd0;
        rob.issue_pc    = 32'd0;
        rob.issue_pred  = 1'b0;
        rob.issue_ready = 1'b0;
        rob.issue_value = 32'd0;
        rob.cdb_valid   = 1'b0;
        rob.cdb_tag     = '0;
        rob.cdb_value   = 32'd0;
        rob.cdb_taken   = 1'b0;
        rob.cdb_target  = 32'd0;
        rob.qa_tag      = '0;
        rob.qb_tag      = '0;
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_in = 1'b1;
        tick();
        rst_in = 1'b0;
    endtask

    task automatic set_issue(input logic [1:0] t, input logic [4:0] rd, input logic [31:0] pc,
                             input logic pred, input logic rdy, input logic [31:0] val);
        rob.issue_valid = 1'b1;
        rob.issue_type  = t;
        rob.issue_rd    = rd;
        rob.issue_pc    = pc;
        rob.issue_pred  = pred;
        rob.issue_ready = rdy;
        rob.issue_value = val;
    endtask

    task automatic set_cdb(input logic [2:0] tag, input logic [31:0] val,
                           input logic taken, input logic [31:0] target);
        rob.cdb_valid  = 1'b1;
        rob.cdb_tag    = tag;
        rob.cdb_value  = val;
        rob.cdb_taken  = taken;
        rob.cdb_target = target;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        iv;
        logic [4:0]  rd;
        logic        cv;
        logic [2:0]  ctag;
        logic [31:0] cval;
        logic [2:0]  qtag;
        logic [2:0]  e_tag;
        logic        e_full;
        logic        e_qrdy;
        logic [31:0] e_qval;
        logic        e_cv;
        logic [2:0]  e_ctag;
        logic [4:0]  e_crd;
        logic [31:0] e_cval;
    } vec_t;

    vec_t vecs[$];

    task automatic run_table();
        vec_t v;
        for (int i = 0; i < 8; i++)
            vecs.push_back(vec_t'{1, 5'(i + 1), 0, 0, 0, 0, 3'(i), 0, 0, 0, 0, 0, 0, 0});
        vecs.push_back(vec_t'{1, 9, 0, 0, 0,          0, 0, 1, 0, 0,          0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 1, 2, 32'h55,     2, 0, 1, 1, 32'h55,     0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 1, 0, 32'h11,     0, 0, 1, 1, 32'h11,     0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0,          2, 0, 1, 1, 32'h55,     1, 0, 1, 32'h11});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0,          1, 0, 0, 0, 0,          0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 1, 1, 32'h22,     1, 0, 0, 1, 32'h22,     0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0,          1, 0, 0, 1, 32'h22,     1, 1, 2, 32'h22});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0,          2, 0, 0, 1, 32'h55,     1, 2, 3, 32'h55});
        vecs.push_back(vec_t'{0, 0, 1, 3, 32'hABCD,   3, 0, 0, 1, 32'hABCD,   0, 0, 0, 0});
        vecs.push_back(vec_t'{0, 0, 0, 0, 0,          3, 0, 0, 1, 32'hABCD,   1, 3, 4, 32'hABCD});

        do_reset();
        foreach (vecs[i]) begin
            v = vecs[i];
            idle_inputs();
            if (v.iv) set_issue(2'd0, v.rd, 32'h1000 + 32'(i * 4), 1'b0, 1'b0, 32'd0);
            if (v.cv) set_cdb(v.ctag, v.cval, 1'b0, 32'd0);
            rob.qa_tag = v.qtag;
            #1;
            check($sformatf("vec%0d issue_tag", i), 32'(rob.issue_tag), 32'(v.e_tag));
            check($sformatf("vec%0d rob_full", i), 32'(rob.rob_full), 32'(v.e_full));
            check($sformatf("vec%0d qa_ready", i), 32'(rob.qa_ready), 32'(v.e_qrdy));
            check($sformatf("vec%0d qa_value", i), rob.qa_value, v.e_qval);
            tick();
            check($sformatf("vec%0d commit_valid", i), 32'(rob.commit_valid), 32'(v.e_cv));
            if (v.e_cv) begin
                check($sformatf("vec%0d commit_tag", i), 32'(rob.commit_tag), 32'(v.e_ctag));
                check($sformatf("vec%0d commit_rd", i), 32'(rob.commit_rd), 32'(v.e_crd));
                check($sformatf("vec%0d commit_value", i), rob.commit_value, v.e_cval);
            end
        end
        idle_inputs();
    endtask

    // ---------------- behavioural model for the random run ----------------
    typedef struct {
        int          tag;
        int          typ;
        logic [4:0]  rd;
        logic [31:0] pc;
        bit          pred;
        bit          rdy;
        logic [31:0] value;
        bit          taken;
        logic [31:0] target;
    } m_ent_t;

    m_ent_t m_q[$];
    int     m_tail;
    bit     m_flush_prev;

    task automatic model_query(input int tag, output logic rdy, output logic [31:0] val);
        rdy = 1'b0;
        val = 32'd0;
        foreach (m_q[i]) begin
            if (m_q[i].tag == tag) begin
                if (rob.cdb_valid && int'(rob.cdb_tag) == tag) begin
                    rdy = 1'b1;
                    val = rob.cdb_value;
                end else if (m_q[i].rdy) begin
                    rdy = 1'b1;
                    val = m_q[i].value;
                end
            end
        end
    endtask

    task automatic run_random(input int cycles);
        logic        e_rdy;
        logic [31:0] e_val;
        bit          full, com, mis, iss;
        m_ent_t      h, n;
        logic [31:0] e_fpc;
        int          pick;

        do_reset();
        m_q.delete();
        m_tail       = 0;
        m_flush_prev = 0;
        for (int c = 0; c < cycles; c++) begin
            idle_inputs();
            rdy_in = ($urandom_range(9) != 0);
            if ($urandom_range(2) != 0)
                set_issue(2'($urandom_range(3)), 5'($urandom), $urandom & ~32'd3,
                          1'($urandom), ($urandom_range(3) == 0), $urandom);
            if ($urandom_range(1) != 0) begin
                pick = -1;
                if (m_q.size() > 0 && $urandom_range(3) != 0) pick = $urandom_range(m_q.size() - 1);
                set_cdb((pick >= 0) ? 3'(m_q[pick].tag) : 3'($urandom_range(7)), $urandom,
                        1'($urandom), $urandom);
                if (pick >= 0 && m_q[pick].typ == 2)
                    rob.cdb_taken = ($urandom_range(4) == 0) ? !m_q[pick].pred : m_q[pick].pred;
            end
            rob.qa_tag = 3'($urandom_range(7));
            rob.qb_tag = ($urandom_range(1) != 0) ? rob.cdb_tag : 3'($urandom_range(7));
            #1;
            check("rnd issue_tag", 32'(rob.issue_tag), 32'(m_tail));
            check("rnd rob_full", 32'(rob.rob_full), 32'(m_q.size() == DEPTH));
            model_query(int'(rob.qa_tag), e_rdy, e_val);
            check("rnd qa_ready", 32'(rob.qa_ready), 32'(e_rdy));
            check("rnd qa_value", rob.qa_value, e_val);
            model_query(int'(rob.qb_tag), e_rdy, e_val);
            check("rnd qb_ready", 32'(rob.qb_ready), 32'(e_rdy));
            check("rnd qb_value", rob.qb_value, e_val);

            full  = (m_q.size() == DEPTH);
            com   = rdy_in && m_q.size() > 0 && m_q[0].rdy;
            h     = (m_q.size() > 0) ? m_q[0] : h;
            mis   = com && h.typ == 2 && h.taken != h.pred;
            iss   = rdy_in && rob.issue_valid && !full && !mis && !m_flush_prev;
            e_fpc = h.taken ? h.target : h.pc + 32'd4;
            if (rdy_in && rob.cdb_valid) begin
                foreach (m_q[i]) begin
                    if (m_q[i].tag == int'(rob.cdb_tag)) begin
                        m_q[i].rdy    = 1;
                        m_q[i].value  = rob.cdb_value;
                        m_q[i].taken  = rob.cdb_taken;
                        m_q[i].target = rob.cdb_target;
                    end
                end
            end
            if (com) void'(m_q.pop_front());
            if (mis) begin
                m_q.delete();
                m_tail = 0;
            end else if (iss) begin
                n.tag    = m_tail;
                n.typ    = int'(rob.issue_type);
                n.rd     = rob.issue_rd;
                n.pc     = rob.issue_pc;
                n.pred   = rob.issue_pred;
                n.rdy    = rob.issue_ready;
                n.value  = rob.issue_value;
                n.taken  = 0;
                n.target = 0;
                m_q.push_back(n);
                m_tail = (m_tail + 1) % DEPTH;
            end
            m_flush_prev = mis;

            tick();
            check("rnd commit_valid", 32'(rob.commit_valid), 32'(com));
            check("rnd commit_store", 32'(rob.commit_store), 32'(com && h.typ == 1));
            check("rnd flush", 32'(rob.flush), 32'(mis));
            if (com) begin
                check("rnd commit_tag", 32'(rob.commit_tag), 32'(h.tag));
                check("rnd commit_rd", 32'(rob.commit_rd), (h.typ == 0) ? 32'(h.rd) : 32'd0);
                check("rnd commit_value", rob.commit_value, h.value);
            end
            if (mis) check("rnd flush_pc", rob.flush_pc, e_fpc);
        end
        idle_inputs();
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_in = 1'b0;
        idle_inputs();
        #2;
        do_reset();

        // reset state
        check("rst issue_tag", 32'(rob.issue_tag), 32'd0);
        check("rst rob_full", 32'(rob.rob_full), 32'd0);
        check("rst commit_valid", 32'(rob.commit_valid), 32'd0);
        check("rst commit_value", rob.commit_value, 32'd0);
        check("rst flush", 32'(rob.flush), 32'd0);
        check("rst flush_pc", rob.flush_pc, 32'd0);

        // fill, refuse 9th, out-of-order CDB with in-order commit, query bypass
        run_table();

        // full ROB: issue refused in the commit cycle, accepted next with the freed tag
        do_reset();
        for (int i = 0; i < DEPTH; i++) begin
            set_issue(2'd0, 5'(i + 10), 32'h2000 + 32'(i * 4), 1'b0, 1'b0, 32'd0);
            tick();
        end
        idle_inputs();
        check("full wrap issue_tag", 32'(rob.issue_tag), 32'd0);
        check("full rob_full", 32'(rob.rob_full), 32'd1);
        set_cdb(3'd0, 32'h7, 1'b0, 32'd0);
        tick();
        idle_inputs();
        set_issue(2'd0, 5'd20, 32'h3000, 1'b0, 1'b1, 32'h77);
        tick();
        check("full+commit commit_valid", 32'(rob.commit_valid), 32'd1);
        check("full+commit commit_tag", 32'(rob.commit_tag), 32'd0);
        check("full+commit issue refused", 32'(rob.issue_tag), 32'd0);
        check("full+commit rob_full", 32'(rob.rob_full), 32'd0);
        set_issue(2'd0, 5'd21, 32'h3004, 1'b0, 1'b1, 32'h78);
        tick();
        idle_inputs();
        check("refill rob_full", 32'(rob.rob_full), 32'd1);
        check("refill issue_tag", 32'(rob.issue_tag), 32'd1);
        check("refill commit_valid", 32'(rob.commit_valid), 32'd0);

        // branch predicted taken, actually not taken
        do_reset();
        set_issue(2'd2, 5'd0, 32'h100, 1'b1, 1'b0, 32'd0);
        tick();
        set_issue(2'd0, 5'd4, 32'h104, 1'b0, 1'b0, 32'd0);
        tick();
        idle_inputs();
        set_cdb(3'd0, 32'd0, 1'b0, 32'h200);
        tick();
        idle_inputs();
        tick();
        check("mispred commit_valid", 32'(rob.commit_valid), 32'd1);
        check("mispred commit_rd", 32'(rob.commit_rd), 32'd0);
        check("mispred flush", 32'(rob.flush), 32'd1);
        check("mispred flush_pc", rob.flush_pc, 32'h104);
        check("mispred rob_full", 32'(rob.rob_full), 32'd0);
        check("mispred tail", 32'(rob.issue_tag), 32'd0);
        rob.qa_tag = 3'd1;
        #1;
        check("mispred query ready", 32'(rob.qa_ready), 32'd0);
        check("mispred query value", rob.qa_value, 32'd0);
        tick();
        check("flush pulse ends", 32'(rob.flush), 32'd0);

        // branch predicted not taken, actually taken: redirect to target
        set_issue(2'd2, 5'd0, 32'h300, 1'b0, 1'b0, 32'd0);
        tick();
        idle_inputs();
        set_cdb(3'd0, 32'd0, 1'b1, 32'h2000);
        tick();
        idle_inputs();
        tick();
        check("taken flush", 32'(rob.flush), 32'd1);
        check("taken flush_pc", rob.flush_pc, 32'h2000);
        tick();

        // store retirement
        set_issue(2'd1, 5'd7, 32'h400, 1'b0, 1'b0, 32'd0);
        tick();
        idle_inputs();
        set_cdb(3'd0, 32'hDEAD, 1'b0, 32'd0);
        tick();
        idle_inputs();
        tick();
        check("store commit_store", 32'(rob.commit_store), 32'd1);
        check("store commit_rd", 32'(rob.commit_rd), 32'd0);
        check("store commit_value", rob.commit_value, 32'hDEAD);
        check("store no flush", 32'(rob.flush), 32'd0);

        // rdy_in low holds a ready head; then asynchronous reset mid-cycle
        do_reset();
        set_issue(2'd0, 5'd9, 32'h40, 1'b0, 1'b1, 32'h99);
        tick();
        rdy_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("stall%0d commit_valid", i), 32'(rob.commit_valid), 32'd0);
            check($sformatf("stall%0d issue_tag", i), 32'(rob.issue_tag), 32'd1);
        end
        idle_inputs();
        tick();
        check("unstall commit_valid", 32'(rob.commit_valid), 32'd1);
        check("unstall commit_rd", 32'(rob.commit_rd), 32'd9);
        check("unstall commit_value", rob.commit_value, 32'h99);
        set_issue(2'd0, 5'd3, 32'h44, 1'b0, 1'b0, 32'd0);
        tick();
        idle_inputs();
        #1;
        rst_in = 1'b1;
        #1;
        check("async rst issue_tag", 32'(rob.issue_tag), 32'd0);
        check("async rst commit_rd", 32'(rob.commit_rd), 32'd0);
        check("async rst commit_value", rob.commit_value, 32'd0);
        tick();
        rst_in = 1'b0;

        // randomized run against the queue model
        run_random(600);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
